// File: rtl/or1k_branch_resolve_if.sv
// Decode/execute branch handshake and resolved-branch feedback between the pipeline and
// or1k_branch_resolve; the pipeline side is the master, the resolver is the slave.
interface or1k_branch_resolve_if #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned STAT_WIDTH           = 16
);
    logic                            padv_decode_i;
    logic                            decode_op_bf_i;
    logic                            decode_op_bnf_i;
    logic                            predicted_flag_i;
    logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i;
    logic [OPTION_OPERAND_WIDTH-1:0] decode_target_i;
    logic                            padv_execute_i;
    logic                            flag_i;
    logic                            pipeline_flush_i;

    logic                            execute_op_bf_o;
    logic                            execute_op_bnf_o;
    logic                            prev_op_brcond_o;
    logic                            predicted_flag_o;
    logic                            branch_mispredict_o;
    logic                            redirect_o;
    logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o;
    logic [STAT_WIDTH-1:0]           stat_branches_o;
    logic [STAT_WIDTH-1:0]           stat_mispredicts_o;

    modport master (
        output padv_decode_i, decode_op_bf_i, decode_op_bnf_i, predicted_flag_i,
               decode_pc_i, decode_target_i, padv_execute_i, flag_i, pipeline_flush_i,
        input  execute_op_bf_o, execute_op_bnf_o, prev_op_brcond_o, predicted_flag_o,
               branch_mispredict_o, redirect_o, redirect_pc_o, stat_branches_o,
               stat_mispredicts_o
    );

    modport slave (
        input  padv_decode_i, decode_op_bf_i, decode_op_bnf_i, predicted_flag_i,
               decode_pc_i, decode_target_i, padv_execute_i, flag_i, pipeline_flush_i,
        output execute_op_bf_o, execute_op_bnf_o, prev_op_brcond_o, predicted_flag_o,
               branch_mispredict_o, redirect_o, redirect_pc_o, stat_branches_o,
               stat_mispredicts_o
    );
endinterface

// File: rtl/or1k_branch_resolve.sv
// Holds a conditional branch from decode into execute, resolves it against SR[F], trains the
// predictor, issues a one-cycle fetch redirect on mispredict and keeps saturating statistics.
module or1k_branch_resolve #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned STAT_WIDTH           = 16
) (
    input logic                 clk,
    input logic                 rst,
    or1k_branch_resolve_if.slave br_io
);

    localparam logic [OPTION_OPERAND_WIDTH-1:0] DelaySlotStep = OPTION_OPERAND_WIDTH'(8);

    typedef enum logic [0:0] {StIdle, StRedirect} state_e;

    state_e                          state_q, state_d;
    logic                            valid_q, valid_d;
    logic                            bf_q, bf_d;
    logic                            bnf_q, bnf_d;
    logic                            pred_q, pred_d;
    logic [OPTION_OPERAND_WIDTH-1:0] pc_q, pc_d;
    logic [OPTION_OPERAND_WIDTH-1:0] target_q, target_d;
    logic                            redirect_q, redirect_d;
    logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [STAT_WIDTH-1:0]           branches_q, branches_d;
    logic [STAT_WIDTH-1:0]           mispredicts_q, mispredicts_d;

    logic in_idle;
    logic taken;
    logic mispredict;
    logic capture;
    logic resolve;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        in_idle    = (state_q == StIdle);
        // bf wins when decode flags both bf and bnf; capture already cleared bnf in that case.
        taken      = bf_q ? br_io.flag_i : (bnf_q & ~br_io.flag_i);
        mispredict = valid_q & (taken != pred_q);
        capture    = br_io.padv_decode_i & in_idle;
        resolve    = valid_q & br_io.padv_execute_i & in_idle;
    end

    always_comb begin
        state_d       = StIdle;
        valid_d       = valid_q;
        bf_d          = bf_q;
        bnf_d         = bnf_q;
        pred_d        = pred_q;
        pc_d          = pc_q;
        target_d      = target_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;

        if (br_io.pipeline_flush_i || !in_idle) begin
            valid_d = 1'b0;
        end else begin
            if (capture) begin
                valid_d  = br_io.decode_op_bf_i | br_io.decode_op_bnf_i;
                bf_d     = br_io.decode_op_bf_i;
                bnf_d    = br_io.decode_op_bnf_i & ~br_io.decode_op_bf_i;
                pred_d   = br_io.predicted_flag_i;
                pc_d     = br_io.decode_pc_i;
                target_d = br_io.decode_target_i;
            end
            if (resolve) begin
                branches_d = sat_inc(branches_q);
                if (mispredict) begin
                    // The instruction in decode is on the wrong path, so it is dropped.
                    mispredicts_d = sat_inc(mispredicts_q);
                    redirect_pc_d = taken ? target_q : pc_q + DelaySlotStep;
                    redirect_d    = 1'b1;
                    state_d       = StRedirect;
                    valid_d       = 1'b0;
                end else if (!capture) begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            valid_q       <= 1'b0;
            bf_q          <= 1'b0;
            bnf_q         <= 1'b0;
            pred_q        <= 1'b0;
            pc_q          <= '0;
            target_q      <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            bf_q          <= bf_d;
            bnf_q         <= bnf_d;
            pred_q        <= pred_d;
            pc_q          <= pc_d;
            target_q      <= target_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign br_io.execute_op_bf_o     = valid_q & bf_q;
    assign br_io.execute_op_bnf_o    = valid_q & bnf_q;
    assign br_io.prev_op_brcond_o    = valid_q;
    assign br_io.predicted_flag_o    = pred_q;
    assign br_io.branch_mispredict_o = mispredict;
    assign br_io.redirect_o          = redirect_q;
    assign br_io.redirect_pc_o       = redirect_pc_q;
    assign br_io.stat_branches_o     = branches_q;
    assign br_io.stat_mispredicts_o  = mispredicts_q;

endmodule

// File: tb/tb_or1k_branch_resolve.sv
// Scoreboard bench for or1k_branch_resolve: expected redirect PCs are queued when a
// mispredicted resolve is driven and popped when redirect_o pulses.
module tb_or1k_branch_resolve;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 4;

    logic clk;
    logic rst;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [W-1:0] sb[$];

    // Model of the held slot and counters.
    logic         m_valid, m_bf, m_bnf, m_pred;
    logic [W-1:0] m_pc, m_tgt;
    int unsigned  exp_br, exp_mp;

    or1k_branch_resolve_if #(.OPTION_OPERAND_WIDTH(W), .STAT_WIDTH(SW)) br ();

    or1k_branch_resolve #(.OPTION_OPERAND_WIDTH(W), .STAT_WIDTH(SW)) dut (
        .clk   (clk),
        .rst   (rst),
        .br_io (br)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v >= (1 << SW) - 1) ? (1 << SW) - 1 : v + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Redirect monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && br.redirect_o) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_redirect", 32'(br.redirect_o), 32'd0);
            end else begin
                check_eq("redirect_pc", br.redirect_pc_o, sb.pop_front());
            end
        end
    end

    task automatic capture(input logic bf, input logic bnf, input logic pred,
                           input logic [W-1:0] pc, input logic [W-1:0] tgt);
        br.padv_decode_i    = 1'b1;
        br.decode_op_bf_i   = bf;
        br.decode_op_bnf_i  = bnf;
        br.predicted_flag_i = pred;
        br.decode_pc_i      = pc;
        br.decode_target_i  = tgt;
        step();
        br.padv_decode_i    = 1'b0;
        m_valid = bf | bnf;
        m_bf    = bf;
        m_bnf   = bnf & ~bf;
        m_pred  = pred;
        m_pc    = pc;
        m_tgt   = tgt;
        check_eq("cap_brcond", 32'(br.prev_op_brcond_o), 32'(m_valid));
        check_eq("cap_bf", 32'(br.execute_op_bf_o), 32'(m_valid & m_bf));
        check_eq("cap_bnf", 32'(br.execute_op_bnf_o), 32'(m_valid & m_bnf));
    endtask

    // Drive the execute-side inputs for one resolve cycle and update the model.
    task automatic drive_resolve(input logic flag, input logic flush, output logic mp);
        logic taken;
        br.padv_execute_i   = 1'b1;
        br.flag_i           = flag;
        br.pipeline_flush_i = flush;
        #1;
        taken = m_bf ? flag : (m_bnf & ~flag);
        mp    = m_valid & (taken != m_pred);
        check_eq("mispredict", 32'(br.branch_mispredict_o), 32'(mp));
        if (m_valid && !flush) begin
            exp_br = sat(exp_br);
            if (mp) begin
                exp_mp = sat(exp_mp);
                sb.push_back(taken ? m_tgt : m_pc + 32'd8);
            end
        end
    endtask

    task automatic resolve(input logic flag, input logic flush);
        logic mp;
        drive_resolve(flag, flush, mp);
        step();
        br.padv_execute_i   = 1'b0;
        br.pipeline_flush_i = 1'b0;
        m_valid = 1'b0;
        check_eq("stat_branches", 32'(br.stat_branches_o), exp_br);
        check_eq("stat_mispredicts", 32'(br.stat_mispredicts_o), exp_mp);
        check_eq("post_brcond", 32'(br.prev_op_brcond_o), 32'd0);
        if (mp && !flush) step();
    endtask

    initial begin
        logic mp;
        n_checks = 0;
        n_errors = 0;
        exp_br   = 0;
        exp_mp   = 0;
        m_valid  = 1'b0;
        m_bf     = 1'b0;
        m_bnf    = 1'b0;
        m_pred   = 1'b0;
        m_pc     = '0;
        m_tgt    = '0;
        br.padv_decode_i    = 1'b0;
        br.decode_op_bf_i   = 1'b0;
        br.decode_op_bnf_i  = 1'b0;
        br.predicted_flag_i = 1'b0;
        br.decode_pc_i      = '0;
        br.decode_target_i  = '0;
        br.padv_execute_i   = 1'b0;
        br.flag_i           = 1'b0;
        br.pipeline_flush_i = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("rst_brcond", 32'(br.prev_op_brcond_o), 32'd0);
        check_eq("rst_redirect", 32'(br.redirect_o), 32'd0);
        check_eq("rst_redirect_pc", br.redirect_pc_o, 32'd0);
        check_eq("rst_stat_br", 32'(br.stat_branches_o), 32'd0);
        check_eq("rst_stat_mp", 32'(br.stat_mispredicts_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step();

        // Correct prediction: bf, pred 1, flag 1.
        capture(1'b1, 1'b0, 1'b1, 32'h100, 32'h200);
        resolve(1'b1, 1'b0);
        // Mispredict: bnf predicted taken, flag 1 -> not taken, pc + 8.
        capture(1'b0, 1'b1, 1'b1, 32'h100, 32'h200);
        resolve(1'b1, 1'b0);
        // PC wrap on not-taken redirect.
        capture(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h40);
        resolve(1'b0, 1'b0);
        // Mispredict not-taken prediction that is taken -> target.
        capture(1'b1, 1'b0, 1'b0, 32'h300, 32'h1234);
        resolve(1'b1, 1'b0);
        // Flush wins over a mispredicted resolve.
        capture(1'b1, 1'b0, 1'b0, 32'h400, 32'h500);
        resolve(1'b1, 1'b1);
        // Both bf and bnf flagged: behaves as bf.
        capture(1'b1, 1'b1, 1'b1, 32'h440, 32'h480);
        resolve(1'b1, 1'b0);
        // Non-branch capture leaves the slot empty.
        capture(1'b0, 1'b0, 1'b1, 32'h460, 32'h470);
        resolve(1'b1, 1'b0);

        // Held branch stays stable while execute stalls.
        capture(1'b0, 1'b1, 1'b1, 32'h480, 32'h4C0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("held_brcond", 32'(br.prev_op_brcond_o), 32'd1);
            check_eq("held_bnf", 32'(br.execute_op_bnf_o), 32'd1);
            check_eq("held_pred", 32'(br.predicted_flag_o), 32'd1);
        end
        resolve(1'b0, 1'b0);

        // Pipelined capture and correct resolve in the same cycle.
        capture(1'b1, 1'b0, 1'b1, 32'h600, 32'h700);
        br.padv_decode_i    = 1'b1;
        br.decode_op_bf_i   = 1'b0;
        br.decode_op_bnf_i  = 1'b1;
        br.predicted_flag_i = 1'b0;
        br.decode_pc_i      = 32'h800;
        br.decode_target_i  = 32'h900;
        drive_resolve(1'b1, 1'b0, mp);
        step();
        br.padv_decode_i  = 1'b0;
        br.padv_execute_i = 1'b0;
        m_valid = 1'b1; m_bf = 1'b0; m_bnf = 1'b1; m_pred = 1'b0;
        m_pc = 32'h800; m_tgt = 32'h900;
        check_eq("pipe_brcond", 32'(br.prev_op_brcond_o), 32'd1);
        check_eq("pipe_bnf", 32'(br.execute_op_bnf_o), 32'd1);
        check_eq("pipe_pred", 32'(br.predicted_flag_o), 32'd0);
        check_eq("pipe_stat_br", 32'(br.stat_branches_o), exp_br);
        resolve(1'b1, 1'b0);

        // Capture during REDIRECT is ignored; a flush there keeps the pulse.
        capture(1'b1, 1'b0, 1'b0, 32'h900, 32'hA00);
        drive_resolve(1'b1, 1'b0, mp);
        step();
        br.padv_execute_i   = 1'b0;
        m_valid = 1'b0;
        check_eq("redir_pulse", 32'(br.redirect_o), 32'd1);
        br.padv_decode_i    = 1'b1;
        br.decode_op_bf_i   = 1'b1;
        br.pipeline_flush_i = 1'b1;
        step();
        br.padv_decode_i    = 1'b0;
        br.pipeline_flush_i = 1'b0;
        check_eq("redir_ignored_cap", 32'(br.prev_op_brcond_o), 32'd0);
        check_eq("redir_one_cycle", 32'(br.redirect_o), 32'd0);

        // Saturation: 20 mispredicts drive both counters to all-ones.
        for (int i = 0; i < 20; i++) begin
            capture(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i * 16), 32'h2000);
            resolve(1'b0, 1'b0);
        end
        check_eq("sat_br", 32'(br.stat_branches_o), 32'd15);
        check_eq("sat_mp", 32'(br.stat_mispredicts_o), 32'd15);

        // Asynchronous reset in the middle of a REDIRECT cycle.
        capture(1'b0, 1'b1, 1'b0, 32'h3000, 32'h3100);
        drive_resolve(1'b0, 1'b0, mp);
        step();
        br.padv_execute_i = 1'b0;
        check_eq("pre_rst_redirect", 32'(br.redirect_o), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        sb.delete();
        m_valid = 1'b0;
        exp_br  = 0;
        exp_mp  = 0;
        check_eq("arst_redirect", 32'(br.redirect_o), 32'd0);
        check_eq("arst_redirect_pc", br.redirect_pc_o, 32'd0);
        check_eq("arst_stat_br", 32'(br.stat_branches_o), 32'd0);
        check_eq("arst_stat_mp", 32'(br.stat_mispredicts_o), 32'd0);
        check_eq("arst_pred", 32'(br.predicted_flag_o), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        step();
        capture(1'b1, 1'b0, 1'b1, 32'h100, 32'h200);
        resolve(1'b1, 1'b0);

        repeat (3) step();
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
